// File: rtl/mdio_slave_pkg.sv
// mdio_slave_pkg: shared MDIO frame constants, field widths and responder state encoding
package mdio_slave_pkg;
  localparam logic [1:0] MDIO_OP_READ = 2'b10;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_ST = 2'b01;
  localparam int OP_W = 2;
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int TA_W = 2;
  localparam int DATA_W = 16;
  localparam int ONES_MAX = 32;
  typedef enum logic [3:0] {
    IDLE, ST2, OP, PHYAD, REGAD, SKIP, RD_TA, RD_DATA, WR_TA, WR_DATA
  } mdioState;
endpackage

// File: rtl/mdio_slave_sync_edge.sv
// mdio_slave_sync_edge: 2-FF synchronizers for MDC/MDIO plus a one-clock MDC rise pulse
module mdio_slave_sync_edge (
  input  logic clk125,
  input  logic reset_n,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdcRise,
  output logic mdioBit
);
  logic [2:0] mdcSr;
  logic [1:0] mdioSr;
  always_ff @(posedge clk125 or negedge reset_n)
    if (!reset_n) begin
      mdcSr <= '0;
      mdioSr <= '0;
    end else begin
      mdcSr <= {mdcSr[1:0], mdc_i};
      mdioSr <= {mdioSr[0], mdio_i};
    end
  // mdioBit sits at the same sync depth as mdcSr[1], so it is the bit present at the rise
  assign mdcRise = mdcSr[1] & ~mdcSr[2];
  assign mdioBit = mdioSr[1];
endmodule

// File: rtl/mdio_slave.sv
// mdio_slave: Clause-22 MDIO responder decoding frames for PHY_ADDR onto a local register bus
module mdio_slave
  import mdio_slave_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int PREAMBLE_MIN = 32
) (
  input  logic        clk125,
  input  logic        reset_n,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic [4:0]  reg_addr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr,
  output logic [15:0] reg_wdata,
  output logic        busy,
  output logic        frame_err
);
  mdioState state, stateNext;
  logic mdcRise, bitIn, frameErrNext, isRead, phyMatch, lastData;
  logic [4:0] bitCnt, fieldNext;
  logic [3:0] fieldSr;
  logic [5:0] onesCnt;
  logic [DATA_W-1:0] rdataSr;
  mdio_slave_sync_edge uSync (
    .clk125 (clk125),
    .reset_n(reset_n),
    .mdc_i  (mdc_i),
    .mdio_i (mdio_i),
    .mdcRise(mdcRise),
    .mdioBit(bitIn)
  );
  assign fieldNext = {fieldSr, bitIn};
  assign lastData = bitCnt == 5'(DATA_W - 1);
  assign busy = state != IDLE && state != ST2;
  always_ff @(posedge clk125 or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    stateNext = state;
    frameErrNext = 1'b0;
    if (mdcRise)
      case (state)
        IDLE: if (bitIn == MDIO_ST[1] && onesCnt >= 6'(PREAMBLE_MIN)) stateNext = ST2;
        ST2: begin
          stateNext = bitIn == MDIO_ST[0] ? OP : IDLE;
          frameErrNext = bitIn != MDIO_ST[0];
        end
        OP: if (bitCnt == 5'(OP_W - 1)) begin
          stateNext = fieldNext[1:0] == MDIO_OP_READ || fieldNext[1:0] == MDIO_OP_WRITE ? PHYAD : IDLE;
          frameErrNext = stateNext == IDLE;
        end
        PHYAD: if (bitCnt == 5'(PHYAD_W - 1)) stateNext = REGAD;
        REGAD: if (bitCnt == 5'(REGAD_W - 1)) stateNext = !phyMatch ? SKIP : isRead ? RD_TA : WR_TA;
        SKIP: if (bitCnt == 5'(TA_W + DATA_W - 1)) stateNext = IDLE;
        RD_TA: if (bitCnt == 5'(TA_W - 1)) stateNext = RD_DATA;
        WR_TA: if (bitCnt == 5'(TA_W - 1)) stateNext = WR_DATA;
        RD_DATA, WR_DATA: if (lastData) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
  end
  always_ff @(posedge clk125 or negedge reset_n)
    if (!reset_n) begin
      mdio_o <= 1'b0;
      mdio_t <= 1'b1;
      reg_addr <= '0;
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
      reg_wdata <= '0;
      frame_err <= 1'b0;
      bitCnt <= '0;
      fieldSr <= '0;
      onesCnt <= '0;
      isRead <= 1'b0;
      phyMatch <= 1'b0;
      rdataSr <= '0;
    end else begin
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
      frame_err <= frameErrNext;
      if (reg_rd) rdataSr <= reg_rdata;
      if (mdcRise) begin
        fieldSr <= fieldNext[3:0];
        bitCnt <= stateNext != state ? '0 : bitCnt + 5'd1;
        // leaving IDLE always zeroes the count, so every frame needs a fresh preamble
        onesCnt <= state == IDLE && bitIn ? (onesCnt == 6'(ONES_MAX) ? onesCnt : onesCnt + 6'd1) : '0;
        if (state == OP) isRead <= fieldNext[1:0] == MDIO_OP_READ;
        if (state == PHYAD) phyMatch <= fieldNext == PHY_ADDR;
        if (state == REGAD && stateNext != REGAD && phyMatch) begin
          reg_addr <= fieldNext;
          reg_rd <= isRead;
        end
        if (state == RD_TA) begin
          mdio_t <= 1'b0;
          mdio_o <= bitCnt != 5'd0 && rdataSr[DATA_W-1];
          if (bitCnt != 5'd0) rdataSr <= {rdataSr[DATA_W-2:0], 1'b0};
        end
        if (state == RD_DATA) begin
          mdio_t <= lastData;
          mdio_o <= !lastData && rdataSr[DATA_W-1];
          rdataSr <= {rdataSr[DATA_W-2:0], 1'b0};
        end
        if (state == WR_DATA) begin
          reg_wdata <= {reg_wdata[DATA_W-2:0], bitIn};
          reg_wr <= lastData;
        end
      end
    end
endmodule

// File: tb/tb_mdio_slave.sv
// tb_mdio_slave: behavioural MDIO master plus 32x16 register model driving mdio_slave with directed frames
module tb_mdio_slave;
  localparam int HALF = 16;
  logic clk125 = 1'b0, reset_n = 1'b0, mdc = 1'b0, masterBit = 1'b1, masterOe = 1'b1;
  logic mdioBus, mdio_o, mdio_t, reg_rd, reg_wr, busy, frame_err;
  logic [4:0] reg_addr;
  logic [15:0] reg_rdata, reg_wdata;
  logic [15:0] mem [32];
  int compared = 0, mismatched = 0;
  int wrCnt = 0, rdCnt = 0, errCnt = 0, bothCnt = 0;
  logic [4:0] lastWrAddr = '0, lastRdAddr = '0;
  logic [15:0] lastWrData = '0;
  always #4 clk125 = ~clk125;
  // pull-up: released bus reads as 1
  assign mdioBus = !mdio_t ? mdio_o : masterOe ? masterBit : 1'b1;
  assign reg_rdata = mem[reg_addr];
  mdio_slave dut (
    .clk125   (clk125),
    .reset_n  (reset_n),
    .mdc_i    (mdc),
    .mdio_i   (mdioBus),
    .mdio_o   (mdio_o),
    .mdio_t   (mdio_t),
    .reg_addr (reg_addr),
    .reg_rd   (reg_rd),
    .reg_rdata(reg_rdata),
    .reg_wr   (reg_wr),
    .reg_wdata(reg_wdata),
    .busy     (busy),
    .frame_err(frame_err)
  );
  always @(negedge clk125) begin
    if (reg_wr) begin
      wrCnt++;
      lastWrAddr = reg_addr;
      lastWrData = reg_wdata;
      mem[reg_addr] = reg_wdata;
    end
    if (reg_rd) begin
      rdCnt++;
      lastRdAddr = reg_addr;
    end
    if (frame_err) errCnt++;
    if (reg_rd && reg_wr) bothCnt++;
  end
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic mdcCycle();
    repeat (HALF) @(negedge clk125);
    mdc = 1'b1;
    repeat (HALF) @(negedge clk125);
    mdc = 1'b0;
  endtask
  task automatic mdioFrame(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] regA,
                           input logic [15:0] wdata, input int abortRise,
                           output logic [15:0] rdata, output logic [17:0] tMask, output logic busyMid);
    logic [13:0] hdr;
    hdr = {2'b01, op, phy, regA};
    rdata = '0;
    tMask = '0;
    busyMid = 1'b0;
    masterOe = 1'b1;
    for (int i = 0; i < pre; i++) begin
      masterBit = 1'b1;
      mdcCycle();
    end
    for (int i = 13; i >= 0; i--) begin
      masterBit = hdr[i];
      mdcCycle();
    end
    for (int r = 0; r < 18; r++) begin
      masterOe = op == 2'b01;
      masterBit = r == 0 ? 1'b1 : r == 1 ? 1'b0 : wdata[17-r];
      repeat (HALF) @(negedge clk125);
      if (r == 0) busyMid = busy;
      if (r == abortRise) begin
        checkVal("abort_pre_drive", {31'd0, mdio_t}, 32'd0);
        reset_n = 1'b0;
        @(negedge clk125);
        checkVal("abort_release", {31'd0, mdio_t}, 32'd1);
        checkVal("abort_busy", {31'd0, busy}, 32'd0);
        checkVal("abort_strobes", {30'd0, reg_rd, reg_wr}, 32'd0);
        repeat (3) @(negedge clk125);
        reset_n = 1'b1;
        masterOe = 1'b1;
        masterBit = 1'b1;
        repeat (4) @(negedge clk125);
        return;
      end
      tMask = {tMask[16:0], mdio_t};
      if (r >= 2) rdata = {rdata[14:0], mdioBus};
      mdc = 1'b1;
      repeat (HALF) @(negedge clk125);
      mdc = 1'b0;
    end
    masterOe = 1'b1;
    masterBit = 1'b1;
    repeat (8) @(negedge clk125);
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: run still active at 1ms, expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [15:0] rd;
    logic [17:0] tm;
    logic bm;
    int w0, r0, e0;
    repeat (5) @(negedge clk125);
    reset_n = 1'b1;
    @(negedge clk125);
    checkVal("rst_mdio_t", {31'd0, mdio_t}, 32'd1);
    checkVal("rst_mdio_o", {31'd0, mdio_o}, 32'd0);
    checkVal("rst_strobes", {30'd0, reg_rd, reg_wr}, 32'd0);
    checkVal("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
    checkVal("rst_reg_wdata", {16'd0, reg_wdata}, 32'd0);
    checkVal("rst_busy_err", {30'd0, busy, frame_err}, 32'd0);
    w0 = wrCnt; e0 = errCnt; r0 = rdCnt;
    mdioFrame(32, 2'b01, 5'd1, 5'd5, 16'hA5C3, -1, rd, tm, bm);
    checkVal("wr_count", wrCnt - w0, 1);
    checkVal("wr_addr", {27'd0, lastWrAddr}, 32'd5);
    checkVal("wr_data", {16'd0, lastWrData}, 32'h0000A5C3);
    checkVal("wr_no_err", errCnt - e0, 0);
    checkVal("wr_no_rd", rdCnt - r0, 0);
    checkVal("wr_busy_mid", {31'd0, bm}, 32'd1);
    checkVal("wr_busy_end", {31'd0, busy}, 32'd0);
    w0 = wrCnt;
    mdioFrame(32, 2'b01, 5'd1, 5'd9, 16'h1234, -1, rd, tm, bm);
    checkVal("preload_count", wrCnt - w0, 1);
    w0 = wrCnt; r0 = rdCnt;
    mdioFrame(32, 2'b10, 5'd1, 5'd9, 16'h0000, -1, rd, tm, bm);
    checkVal("rd_count", rdCnt - r0, 1);
    checkVal("rd_addr", {27'd0, lastRdAddr}, 32'd9);
    checkVal("rd_data", {16'd0, rd}, 32'h00001234);
    checkVal("rd_tmask", {14'd0, tm}, 32'h00020000);
    checkVal("rd_released", {31'd0, mdio_t}, 32'd1);
    checkVal("rd_no_wr", wrCnt - w0, 0);
    w0 = wrCnt; r0 = rdCnt;
    mdioFrame(32, 2'b10, 5'd3, 5'd9, 16'h0000, -1, rd, tm, bm);
    checkVal("nomatch_strobes", (wrCnt - w0) + (rdCnt - r0), 0);
    checkVal("nomatch_tmask", {14'd0, tm}, 32'h0003FFFF);
    checkVal("nomatch_data", {16'd0, rd}, 32'h0000FFFF);
    w0 = wrCnt; r0 = rdCnt; e0 = errCnt;
    mdioFrame(32, 2'b11, 5'd1, 5'd7, 16'h5A5A, -1, rd, tm, bm);
    checkVal("badop_err", errCnt - e0, 1);
    checkVal("badop_strobes", (wrCnt - w0) + (rdCnt - r0), 0);
    w0 = wrCnt;
    mdioFrame(32, 2'b01, 5'd1, 5'd7, 16'h5A5A, -1, rd, tm, bm);
    checkVal("after_err_wr", wrCnt - w0, 1);
    checkVal("after_err_addr", {27'd0, lastWrAddr}, 32'd7);
    checkVal("after_err_data", {16'd0, lastWrData}, 32'h00005A5A);
    w0 = wrCnt; e0 = errCnt;
    mdioFrame(31, 2'b01, 5'd1, 5'd6, 16'h0F0F, -1, rd, tm, bm);
    checkVal("pre31_ignored", wrCnt - w0, 0);
    checkVal("pre31_no_err", errCnt - e0, 0);
    w0 = wrCnt;
    mdioFrame(32, 2'b01, 5'd1, 5'd6, 16'h0F0F, -1, rd, tm, bm);
    checkVal("pre32_wr", wrCnt - w0, 1);
    checkVal("pre32_addr", {27'd0, lastWrAddr}, 32'd6);
    checkVal("pre32_data", {16'd0, lastWrData}, 32'h00000F0F);
    w0 = wrCnt;
    mdioFrame(32, 2'b10, 5'd1, 5'd9, 16'h0000, 10, rd, tm, bm);
    checkVal("abort_no_wr", wrCnt - w0, 0);
    r0 = rdCnt;
    mdioFrame(32, 2'b10, 5'd1, 5'd9, 16'h0000, -1, rd, tm, bm);
    checkVal("post_rst_rd_count", rdCnt - r0, 1);
    checkVal("post_rst_rd_data", {16'd0, rd}, 32'h00001234);
    checkVal("never_both_strobes", bothCnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
